mem_port_arbiter: RTL and testbench

Sequencing arbiter for the CPU's single 32-bit memory port. It shares the port between the instruction-fetch requester (port A) and the load/store requester (port B). It drives the select of the 32-bit 2:1 address/data mux in front of memory, with 0 selecting A and 1 selecting B. It latches each transaction, holds the memory request until memory answers, and returns read data and a one-cycle acknowledge to the winning requester.

---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the CPU's single 32-bit memory port between the
// instruction-fetch requester (port A) and the load/store requester (port B).
// Each access is latched at grant and held until memory answers or the wait
// counter expires. The winning port then gets read data and a one-cycle ack.
// All outputs are registered.
//
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to alternate grants when
// both ports request in the same cycle. When it is undefined, port B always
// wins a tie.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic [31:0] addr_a,
  input  logic        req_b,
  input  logic        we_b,
  input  logic [31:0] addr_b,
  input  logic [31:0] wdata_b,
  output logic        ack_a,
  output logic        ack_b,
  output logic [31:0] rdata,
  output logic        err,
  output logic        sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state, state_n;
  logic [7:0]  wait_cnt, wait_cnt_n, wait_inc;
  logic        sel_n, mem_req_n, mem_we_n, ack_a_n, ack_b_n, err_n;
  logic [31:0] mem_addr_n, mem_wdata_n, rdata_n;
  logic        grant_b;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant, last_grant_n;

  // On a tie, grant the port that was not served last. A single request wins outright.
  always_comb begin
    if (req_a && req_b) grant_b = ~last_grant;
    else                grant_b = req_b;
  end
`else
  // Fixed priority: a load/store beats a fetch so data accesses cannot starve.
  always_comb begin
    grant_b = req_b;
  end
`endif

  // Compute the next state and the next value of every registered output.
  always_comb begin
    state_n     = state;
    wait_cnt_n  = wait_cnt;
    wait_inc    = wait_cnt + 8'd1;
    sel_n       = sel;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    rdata_n     = rdata;
    ack_a_n     = 1'b0;
    ack_b_n     = 1'b0;
    err_n       = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_grant_n = last_grant;
`endif
    case (state)
      IDLE: begin
        if (req_a || req_b) begin
          sel_n       = grant_b;
          mem_addr_n  = grant_b ? addr_b : addr_a;
          mem_we_n    = grant_b & we_b;
          mem_wdata_n = grant_b ? wdata_b : 32'h0;
          wait_cnt_n  = 8'd0;
          mem_req_n   = 1'b1;
          state_n     = BUSY;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_n = grant_b;
`endif
        end
      end
      BUSY: begin
        if (mem_ready) begin
          rdata_n   = mem_rdata;
          mem_req_n = 1'b0;
          ack_a_n   = ~sel;
          ack_b_n   = sel;
          state_n   = DONE;
        end else begin
          wait_cnt_n = wait_inc;
          if (wait_inc == TIMEOUT_CNT) begin
            rdata_n   = 32'h0;
            err_n     = 1'b1;
            mem_req_n = 1'b0;
            ack_a_n   = ~sel;
            ack_b_n   = sel;
            state_n   = DONE;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Register the state and outputs. Reset drops any in-flight access without an ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= 8'd0;
      sel       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      rdata     <= 32'h0;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      err       <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant <= 1'b1;
`endif
    end else begin
      state     <= state_n;
      wait_cnt  <= wait_cnt_n;
      sel       <= sel_n;
      mem_req   <= mem_req_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      rdata     <= rdata_n;
      ack_a     <= ack_a_n;
      ack_b     <= ack_b_n;
      err       <= err_n;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant <= last_grant_n;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter, built with TIMEOUT = 4.
// A table of complete transactions runs first. Hand-written sequences then
// cover reset, reset during a wait, and mem_ready arriving outside BUSY.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_a, req_b, we_b, mem_ready;
  logic [31:0] addr_a, addr_b, wdata_b, mem_rdata;
  logic        ack_a, ack_b, err, sel, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .addr_a(addr_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .ack_a(ack_a), .ack_b(ack_b), .rdata(rdata), .err(err),
    .sel(sel), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Stop a runaway simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    string       name;
    logic        req_a, req_b, we_b;
    logic [31:0] addr_a, addr_b, wdata_b, mem_data;
    int          wait_k;
    logic        drop_early;
    logic        exp_sel, exp_we, chk_wdata;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic        exp_ack_a, exp_ack_b, exp_err;
    int          exp_busy;
  } vec_t;

  vec_t vecs[10];
  vec_t post_rst;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare one value and report a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Check that every output is at its reset value.
  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " ack_a"},     32'(ack_a),   32'h0);
    checkOutput({tag, " ack_b"},     32'(ack_b),   32'h0);
    checkOutput({tag, " err"},       32'(err),     32'h0);
    checkOutput({tag, " mem_req"},   32'(mem_req), 32'h0);
    checkOutput({tag, " mem_we"},    32'(mem_we),  32'h0);
    checkOutput({tag, " sel"},       32'(sel),     32'h0);
    checkOutput({tag, " mem_addr"},  mem_addr,     32'h0);
    checkOutput({tag, " mem_wdata"}, mem_wdata,    32'h0);
    checkOutput({tag, " rdata"},     rdata,        32'h0);
  endtask

  // Run one complete transaction from IDLE, churning the inputs while the access is in flight.
  task automatic applyStimulus(input vec_t v);
    int   cycles;
    logic early_ack, frozen_ok;
    req_a = v.req_a; req_b = v.req_b; we_b = v.we_b;
    addr_a = v.addr_a; addr_b = v.addr_b; wdata_b = v.wdata_b;
    mem_rdata = v.mem_data; mem_ready = 1'b0;
    tick();
    checkOutput({v.name, " grant mem_req"}, 32'(mem_req), 32'h1);
    checkOutput({v.name, " sel"},           32'(sel),     32'(v.exp_sel));
    checkOutput({v.name, " mem_addr"},      mem_addr,     v.exp_addr);
    checkOutput({v.name, " mem_we"},        32'(mem_we),  32'(v.exp_we));
    if (v.chk_wdata) checkOutput({v.name, " mem_wdata"}, mem_wdata, v.exp_wdata);
    addr_a = ~v.addr_a; addr_b = ~v.addr_b; wdata_b = ~v.wdata_b; we_b = ~v.we_b;
    if (v.drop_early) begin
      req_a = 1'b0;
      req_b = 1'b0;
    end
    cycles = 0; early_ack = 1'b0; frozen_ok = 1'b1;
    while (mem_req === 1'b1 && cycles < 40) begin
      if (ack_a || ack_b || err) early_ack = 1'b1;
      if (sel !== v.exp_sel || mem_addr !== v.exp_addr || mem_we !== v.exp_we) frozen_ok = 1'b0;
      mem_ready = (cycles == v.wait_k);
      tick();
      cycles++;
    end
    mem_ready = 1'b0;
    checkOutput({v.name, " busy cycles"},   32'(cycles),    32'(v.exp_busy));
    checkOutput({v.name, " early ack"},     32'(early_ack), 32'h0);
    checkOutput({v.name, " frozen in busy"},32'(frozen_ok), 32'h1);
    checkOutput({v.name, " done mem_addr"}, mem_addr,       v.exp_addr);
    checkOutput({v.name, " ack_a"},         32'(ack_a),     32'(v.exp_ack_a));
    checkOutput({v.name, " ack_b"},         32'(ack_b),     32'(v.exp_ack_b));
    checkOutput({v.name, " err"},           32'(err),       32'(v.exp_err));
    checkOutput({v.name, " rdata"},         rdata,          v.exp_rdata);
    req_a = 1'b0; req_b = 1'b0;
    tick();
    checkOutput({v.name, " ack_a cleared"}, 32'(ack_a), 32'h0);
    checkOutput({v.name, " ack_b cleared"}, 32'(ack_b), 32'h0);
    checkOutput({v.name, " err cleared"},   32'(err),   32'h0);
  endtask

  initial begin
    int   stray;
    // Field order: name, req_a, req_b, we_b, addr_a, addr_b, wdata_b, mem_data, wait_k, drop_early,
    //   exp_sel, exp_we, chk_wdata, exp_addr, exp_wdata, exp_rdata, exp_ack_a, exp_ack_b, exp_err, exp_busy
`ifdef MEM_ARB_ROUND_ROBIN_EN
    vecs[0] = '{"simul1", 1'b1, 1'b1, 1'b1, 32'hA0, 32'hB0, 32'h55, 32'h11111111, 0, 1'b0,
                1'b0, 1'b0, 1'b0, 32'hA0, 32'h0, 32'h11111111, 1'b1, 1'b0, 1'b0, 1};
    vecs[1] = '{"simul2", 1'b1, 1'b1, 1'b1, 32'hA0, 32'hB0, 32'h55, 32'h22222222, 0, 1'b0,
                1'b1, 1'b1, 1'b1, 32'hB0, 32'h55, 32'h22222222, 1'b0, 1'b1, 1'b0, 1};
    vecs[2] = '{"simul3", 1'b1, 1'b1, 1'b1, 32'hA0, 32'hB0, 32'h55, 32'h33333333, 0, 1'b0,
                1'b0, 1'b0, 1'b0, 32'hA0, 32'h0, 32'h33333333, 1'b1, 1'b0, 1'b0, 1};
`else
    vecs[0] = '{"simul1", 1'b1, 1'b1, 1'b1, 32'hA0, 32'hB0, 32'h55, 32'h11111111, 0, 1'b0,
                1'b1, 1'b1, 1'b1, 32'hB0, 32'h55, 32'h11111111, 1'b0, 1'b1, 1'b0, 1};
    vecs[1] = '{"simul2", 1'b1, 1'b1, 1'b1, 32'hA0, 32'hB0, 32'h55, 32'h22222222, 0, 1'b0,
                1'b1, 1'b1, 1'b1, 32'hB0, 32'h55, 32'h22222222, 1'b0, 1'b1, 1'b0, 1};
    vecs[2] = '{"simul3", 1'b1, 1'b1, 1'b1, 32'hA0, 32'hB0, 32'h55, 32'h33333333, 0, 1'b0,
                1'b1, 1'b1, 1'b1, 32'hB0, 32'h55, 32'h33333333, 1'b0, 1'b1, 1'b0, 1};
`endif
    vecs[3] = '{"fetch0", 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 32'hDEADBEEF, 0, 1'b0,
                1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1};
    vecs[4] = '{"store3", 1'b0, 1'b1, 1'b1, 32'h0, 32'h100, 32'h12345678, 32'hCAFE0001, 3, 1'b0,
                1'b1, 1'b1, 1'b1, 32'h100, 32'h12345678, 32'hCAFE0001, 1'b0, 1'b1, 1'b0, 4};
    vecs[5] = '{"load_to", 1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 32'hAAAA0000, 32'h77777777, 99, 1'b0,
                1'b1, 1'b0, 1'b1, 32'h200, 32'hAAAA0000, 32'h0, 1'b0, 1'b1, 1'b1, 4};
    vecs[6] = '{"retry", 1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 32'hAAAA0000, 32'h77777777, 3, 1'b0,
                1'b1, 1'b0, 1'b1, 32'h200, 32'hAAAA0000, 32'h77777777, 1'b0, 1'b1, 1'b0, 4};
    vecs[7] = '{"fetch_drop", 1'b1, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h13579BDF, 2, 1'b1,
                1'b0, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h13579BDF, 1'b1, 1'b0, 1'b0, 3};
    vecs[8] = '{"fetch_to", 1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 32'h0, 32'h00000005, 99, 1'b0,
                1'b0, 1'b0, 1'b0, 32'h80, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 4};
    vecs[9] = '{"load1", 1'b0, 1'b1, 1'b0, 32'h0, 32'h104, 32'h0, 32'h0BADF00D, 1, 1'b0,
                1'b1, 1'b0, 1'b1, 32'h104, 32'h0, 32'h0BADF00D, 1'b0, 1'b1, 1'b0, 2};
    post_rst = '{"post_rst", 1'b1, 1'b0, 1'b0, 32'h48, 32'h0, 32'h0, 32'h600DF00D, 1, 1'b0,
                1'b0, 1'b0, 1'b0, 32'h48, 32'h0, 32'h600DF00D, 1'b1, 1'b0, 1'b0, 2};

    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; we_b = 1'b0;
    addr_a = 32'h0; addr_b = 32'h0; wdata_b = 32'h0;
    mem_rdata = 32'h0; mem_ready = 1'b0;
    tick();
    tick();
    checkResetOutputs("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    $display("[TB] reset during a wait");
    req_a = 1'b1; addr_a = 32'h44;
    tick();
    checkOutput("rst_mid grant mem_req", 32'(mem_req), 32'h1);
    checkOutput("rst_mid grant mem_addr", mem_addr, 32'h44);
    tick();
    rst_n = 1'b0;
    tick();
    checkResetOutputs("rst_mid");
    rst_n = 1'b1; req_a = 1'b0; mem_ready = 1'b1;
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ack_a || ack_b || err || mem_req) stray++;
    end
    checkOutput("rst_mid no ack and ready ignored", 32'(stray), 32'h0);
    mem_ready = 1'b0;
    applyStimulus(post_rst);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
